// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard controller: load-use and multiplier stalls, branch flush.
// Optional stall performance counter enabled by HAZARD_PERF_CNT_EN.
module hazard_stall_unit #(
    parameter int MUL_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic             id_is_mul,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [3:0] MUL_INIT = 4'(MUL_LATENCY - 1);

    logic [3:0] mul_cnt;
    logic [4:0] mul_rd;
    logic       rs1_used;
    logic       rs2_used;
    logic       load_use;
    logic       mul_dep;
    logic       mul_haz;
    logic       stall;
    logic       flush;
    logic       mul_issue;

    // Which source operands the ID opcode actually reads
    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        unique case (id_opcode)
            OP_R, OP_BRANCH, OP_STORE: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OP_I, OP_LOAD: begin
                rs1_used = 1'b1;
            end
            default: begin
                rs1_used = 1'b0;
                rs2_used = 1'b0;
            end
        endcase
    end

    // Busy is masked during reset so it drops in the same cycle rst rises
    assign mul_busy = !rst && (mul_cnt != 4'd0);

    assign load_use = id_valid && ex_mem_read && (ex_rd != 5'd0) &&
                      ((rs1_used && (id_rs1 == ex_rd)) ||
                       (rs2_used && (id_rs2 == ex_rd)));

    assign mul_dep  = (mul_rd != 5'd0) &&
                      ((rs1_used && (id_rs1 == mul_rd)) ||
                       (rs2_used && (id_rs2 == mul_rd)));

    assign mul_haz  = id_valid && mul_busy && (id_is_mul || mul_dep);

    assign stall     = load_use || mul_haz;
    assign flush     = ex_branch_taken;
    assign mul_issue = id_valid && id_is_mul && !stall && !flush;

    // Pipeline control; reset forces free-running, flush overrides stall
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        if (rst) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_bubble = 1'b0;
            if_id_flush  = 1'b0;
        end else if (flush) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
        end else if (stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // Multiplier occupancy counter and captured destination register
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_cnt <= 4'd0;
            mul_rd  <= 5'd0;
        end else if (mul_issue) begin
            mul_cnt <= MUL_INIT;
            mul_rd  <= id_rd;
        end else if (mul_cnt != 4'd0) begin
            mul_cnt <= mul_cnt - 4'd1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Count cycles lost to stalls; flushed cycles are not stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && !flush) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed testbench for hazard_stall_unit (MUL_LATENCY=4).
// Inputs change 1 time unit after the rising edge, outputs sampled at the falling edge.
module tb_hazard_stall_unit;

    localparam int CNT_W = 32;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [6:0]       id_opcode;
    logic             id_is_mul;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rd;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             ex_branch_taken;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic             mul_busy;
    logic [CNT_W-1:0] stall_cycles;

    int tests = 0;
    int failed = 0;

    hazard_stall_unit #(.MUL_LATENCY(4), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_opcode       (id_opcode),
        .id_is_mul       (id_is_mul),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .id_ex_bubble    (id_ex_bubble),
        .if_id_flush     (if_id_flush),
        .mul_busy        (mul_busy),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [6:0] op, input logic m,
                          input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd);
        id_valid  = v;
        id_opcode = op;
        id_is_mul = m;
        id_rs1    = r1;
        id_rs2    = r2;
        id_rd     = rd;
    endtask

    task automatic set_ex(input logic mr, input logic [4:0] rd, input logic bt);
        ex_mem_read     = mr;
        ex_rd           = rd;
        ex_branch_taken = bt;
    endtask

    // Expected order: {pc_write, if_id_write, id_ex_bubble, if_id_flush, mul_busy}
    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        @(negedge clk);
        obs = {pc_write, if_id_write, id_ex_bubble, if_id_flush, mul_busy};
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] exp);
        tests++;
        assert (stall_cycles === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, stall_cycles, exp);
        end
    endtask

    localparam logic [4:0] CLEAR = 5'b11000;
    localparam logic [4:0] STALL = 5'b00100;
    localparam logic [4:0] STALL_BUSY = 5'b00101;
    localparam logic [4:0] FLUSH = 5'b11110;
    localparam logic [4:0] FLUSH_BUSY = 5'b11111;
    localparam logic [4:0] BUSY = 5'b11001;

    initial begin
        // Reset with a live load-use pattern: outputs must still be forced
        rst = 1'b1;
        set_id(1'b1, OP_R, 1'b0, 5'd5, 5'd1, 5'd6);
        set_ex(1'b1, 5'd5, 1'b0);
        chk_ctl("reset_forced", CLEAR);
        chk_cnt("reset_cnt", '0);
        tick();
        rst = 1'b0;
        set_id(1'b0, OP_R, 1'b0, 5'd0, 5'd0, 5'd0);
        set_ex(1'b0, 5'd0, 1'b0);
        chk_ctl("idle", CLEAR);
        tick();

        // 1: ld x5 ; add x6,x5,x1 -> one stall cycle
        set_id(1'b1, OP_R, 1'b0, 5'd5, 5'd1, 5'd6);
        set_ex(1'b1, 5'd5, 1'b0);
        chk_ctl("load_use_stall", STALL);
        tick();
        set_ex(1'b0, 5'd0, 1'b0);
        chk_ctl("load_use_clear", CLEAR);
        tick();

        // 2: x0 never hazards; JAL reads nothing
        set_id(1'b1, OP_R, 1'b0, 5'd0, 5'd0, 5'd6);
        set_ex(1'b1, 5'd0, 1'b0);
        chk_ctl("x0_no_stall", CLEAR);
        tick();
        set_id(1'b1, OP_JAL, 1'b0, 5'd5, 5'd5, 5'd1);
        set_ex(1'b1, 5'd5, 1'b0);
        chk_ctl("jal_no_stall", CLEAR);
        tick();
        set_id(1'b1, OP_I, 1'b0, 5'd1, 5'd5, 5'd2);
        chk_ctl("itype_rs2_unused", CLEAR);
        tick();
        set_id(1'b1, OP_ST, 1'b0, 5'd1, 5'd5, 5'd0);
        chk_ctl("store_rs2_stall", STALL);
        tick();
        set_id(1'b1, OP_R, 1'b0, 5'd1, 5'd5, 5'd0);
        set_ex(1'b1, 5'd5, 1'b0);
        id_valid = 1'b0;
        chk_ctl("invalid_no_stall", CLEAR);
        tick();

        // Clear the perf counter before the MUL test
        rst = 1'b1;
        set_id(1'b0, OP_R, 1'b0, 5'd0, 5'd0, 5'd0);
        set_ex(1'b0, 5'd0, 1'b0);
        tick();
        rst = 1'b0;

        // 3: mul x7 then a consumer of x7 -> 3 stall cycles
        set_id(1'b1, OP_R, 1'b1, 5'd1, 5'd2, 5'd7);
        chk_ctl("mul_issue", CLEAR);
        tick();
        set_id(1'b1, OP_R, 1'b0, 5'd7, 5'd1, 5'd8);
        for (int i = 0; i < 3; i++) begin
            chk_ctl($sformatf("mul_data_stall_%0d", i), STALL_BUSY);
            tick();
        end
        chk_ctl("mul_data_release", CLEAR);
`ifdef HAZARD_PERF_CNT_EN
        chk_cnt("perf_cnt_3", 32'd3);
`else
        chk_cnt("perf_cnt_off", '0);
`endif
        tick();

        // 4: back-to-back independent MULs -> structural stall 3 cycles
        set_id(1'b1, OP_R, 1'b1, 5'd1, 5'd2, 5'd9);
        chk_ctl("mul_a_issue", CLEAR);
        tick();
        set_id(1'b1, OP_R, 1'b1, 5'd3, 5'd4, 5'd10);
        for (int i = 0; i < 3; i++) begin
            chk_ctl($sformatf("mul_struct_stall_%0d", i), STALL_BUSY);
            tick();
        end
        chk_ctl("mul_b_issue", CLEAR);
        tick();
        set_id(1'b0, OP_R, 1'b0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        chk_ctl("mul_drained", CLEAR);

        // 5: flush beats load-use and a MUL in ID; MUL never starts
        set_id(1'b1, OP_R, 1'b1, 5'd5, 5'd2, 5'd11);
        set_ex(1'b1, 5'd5, 1'b1);
        chk_ctl("flush_overrides", FLUSH);
        tick();
        set_id(1'b0, OP_R, 1'b0, 5'd0, 5'd0, 5'd0);
        set_ex(1'b0, 5'd0, 1'b0);
        chk_ctl("flushed_mul_no_busy", CLEAR);
        tick();

        // A MUL already in EX survives a flush; then reset at mul_cnt=2
        set_id(1'b1, OP_R, 1'b1, 5'd1, 5'd2, 5'd12);
        chk_ctl("mul_c_issue", CLEAR);
        tick();
        set_id(1'b0, OP_R, 1'b0, 5'd0, 5'd0, 5'd0);
        set_ex(1'b0, 5'd0, 1'b1);
        chk_ctl("flush_keeps_ex_mul", FLUSH_BUSY);
        tick();
        set_ex(1'b0, 5'd0, 1'b0);
        chk_ctl("busy_cnt2", BUSY);
        rst = 1'b1;
        set_id(1'b1, OP_R, 1'b0, 5'd12, 5'd1, 5'd3);
        chk_ctl("rst_busy_immediate", CLEAR);
        tick();
        rst = 1'b0;

        // 6: after reset, old MUL destination no longer hazards
        chk_ctl("post_rst_clear", CLEAR);
        chk_cnt("post_rst_cnt", '0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
